// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller for the execute-stage MUL unit.
// Drives one shared external WIDTH-bit adder once per cycle for WIDTH cycles
// and returns the low WIDTH bits of op_a*op_b with a fixed latency.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] accStep;
  logic             lastStep;

  // The accumulator only takes the adder sum when the current multiplier bit is set
  assign accStep  = mplier_q[0] ? add_sum : acc_q;
  assign lastStep = (cnt_q == CW'(WIDTH - 1));

  assign add_a  = acc_q;
  assign add_b  = ((state_q == RUN) && mplier_q[0]) ? mcand_q : '0;
  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Datapath next-state: load operands on acceptance, shift-and-add while running
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (lastStep) begin
          result_d = accStep;
        end
      end
      default: begin
      end
    endcase
  end

  // Sequencer: fixed WIDTH-cycle RUN, single-cycle DONE, with status flags registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (lastStep) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl with a behavioural ripple adder model.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_sum;

  int tests;
  int fails;
  int cycleCnt;
  int doneCnt;
  int opsExpected;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_sum(add_sum)
  );

  // External adder shared with the execute stage
  assign add_sum = add_a + add_b;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp and done-pulse tally
  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(negedge clk) if (done === 1'b1) doneCnt <= doneCnt + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full multiply from IDLE; optionally pokes start during RUN cycle 10 and during DONE
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] expected,
                               input string tag, input bit zeroB, input bit inject);
    int cyc;
    int busyCnt;
    bit sawAddB;
    checkOutput({tag, " ready before"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    opsExpected++;
    checkOutput({tag, " ready drops"}, {31'd0, ready}, 32'd0);
    cyc = 1;
    busyCnt = 0;
    sawAddB = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busyCnt++;
      if (add_b !== '0) sawAddB = 1'b1;
      if (inject && cyc == 10) begin
        start = 1'b1;
        op_a  = 32'd2;
        op_b  = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 32'd33);
    checkOutput({tag, " busy cycles"}, busyCnt, 32'd32);
    checkOutput({tag, " result"}, result, expected);
    checkOutput({tag, " busy in done"}, {31'd0, busy}, 32'd0);
    if (zeroB) checkOutput({tag, " add_b zero"}, {31'd0, sawAddB}, 32'd0);
    if (inject) begin
      start = 1'b1;
      op_a  = 32'd2;
      op_b  = 32'd2;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " done pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " ready after"}, {31'd0, ready}, 32'd1);
    checkOutput({tag, " result held"}, result, expected);
  endtask

  initial begin
    int n;
    int lastDone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rexp;
    tests = 0;
    fails = 0;
    cycleCnt = 0;
    doneCnt = 0;
    opsExpected = 0;
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #2;
    checkOutput("reset ready", {31'd0, ready}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset add_a", add_a, 32'd0);
    checkOutput("reset add_b", add_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(32'd3, 32'd5, 32'd15, "3x5", 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "ffxff", 1'b0, 1'b0);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap", 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'd0, 32'd0, "zero b", 1'b1, 1'b0);
    applyStimulus(32'd7, 32'd6, 32'd42, "ignored start", 1'b0, 1'b1);

    // Abort a run part-way with an asynchronous reset
    start = 1'b1;
    op_a  = 32'd100;
    op_b  = 32'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("abort busy before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort ready", {31'd0, ready}, 32'd1);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    checkOutput("abort add_a", add_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'd9, 32'd9, 32'd81, "9x9", 1'b0, 1'b0);

    // Back-to-back with start held high and operands scrambled after acceptance
    lastDone = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      ra = $urandom;
      rb = $urandom;
      rexp = ra * rb;
      op_a = ra;
      op_b = rb;
      @(negedge clk);
      opsExpected++;
      op_a = $urandom;
      op_b = $urandom;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (i == 39) start = 1'b0;
      checkOutput($sformatf("b2b %0d latency", i), n, 32'd33);
      checkOutput($sformatf("b2b %0d result", i), result, rexp);
      if (i > 0) checkOutput($sformatf("b2b %0d spacing", i), cycleCnt - lastDone, 32'd34);
      lastDone = cycleCnt;
    end
    repeat (4) @(negedge clk);
    checkOutput("done pulse count", doneCnt, opsExpected);
    checkOutput("final idle", {31'd0, ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
